// File: rtl/vgamem_console_if.sv
// Character-stream and vgamem write-port bundle for the text console controller.
// The controller takes the slave side; the character source / memory side is master.
interface vgamem_console_if #(parameter int AW = 12);
  logic          ch_valid;
  logic [7:0]    ch_data;
  logic          ch_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [4:0]    top_row;
  logic [4:0]    cur_row;
  logic [6:0]    cur_col;
  logic          cursor_vis;

  modport master (
    output ch_valid, ch_data,
    input  ch_ready, mem_we, mem_addr, mem_wdata, top_row, cur_row, cur_col, cursor_vis
  );

  modport slave (
    input  ch_valid, ch_data,
    output ch_ready, mem_we, mem_addr, mem_wdata, top_row, cur_row, cur_col, cursor_vis
  );
endinterface

// File: rtl/vgamem_console_ctrl.sv
// 70x30 text console writer: cursor tracking, wrap, backspace and scroll via circular top_row.
// Optional macro CURSOR_BLINK_EN adds a blinking cursor with period parameter BLINK_CYCLES.
module vgamem_console_ctrl #(
  parameter int         COLS  = 70,
  parameter int         ROWS  = 30,
  parameter int         AW    = 12,
`ifdef CURSOR_BLINK_EN
  parameter int         BLINK_CYCLES = 25_000_000,
`endif
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic            clk,
  input  logic            rst,
  vgamem_console_if.slave bus
);

  localparam int CELLS = COLS * ROWS;

  typedef enum logic [2:0] {
    S_CLR_ALL, S_IDLE, S_WRITE, S_NEWLINE, S_CLR_LINE, S_BKSP
  } state_t;

  state_t        state, state_d;
  logic [AW-1:0] cnt, cnt_d;
  logic [4:0]    cur_row, cur_row_d, top_row, top_row_d;
  logic [6:0]    cur_col, cur_col_d;
  logic          mem_we, mem_we_d;
  logic [AW-1:0] mem_addr, mem_addr_d;
  logic [7:0]    mem_wdata, mem_wdata_d;
  logic          accept;

  function automatic logic [4:0] row_inc(input logic [4:0] r);
    return (r == 5'(ROWS - 1)) ? 5'd0 : r + 5'd1;
  endfunction

  function automatic logic [4:0] row_dec(input logic [4:0] r);
    return (r == 5'd0) ? 5'(ROWS - 1) : r - 5'd1;
  endfunction

  // row*70 + col built from shifts so no multiplier is inferred
  function automatic logic [AW-1:0] cell_addr(input logic [4:0] r, input logic [6:0] c);
    logic [AW-1:0] rw;
    rw = AW'(r);
    return (rw << 6) + (rw << 2) + (rw << 1) + AW'(c);
  endfunction

  assign accept = bus.ch_valid && (state == S_IDLE);

  // Write-port registers are loaded on the edge that enters a writing state,
  // so each write is on the bus during the state that owns it.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    cur_row_d   = cur_row;
    cur_col_d   = cur_col;
    top_row_d   = top_row;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    case (state)
      S_CLR_ALL: begin
        if (cnt == AW'(CELLS)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt;
          mem_wdata_d = BLANK;
          cnt_d       = cnt + AW'(1);
        end
      end
      S_IDLE: begin
        if (accept) begin
          if (bus.ch_data >= 8'h20 && bus.ch_data <= 8'h7E) begin
            state_d     = S_WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = cell_addr(cur_row, cur_col);
            mem_wdata_d = bus.ch_data;
          end else if (bus.ch_data == 8'h0A || bus.ch_data == 8'h0D) begin
            state_d = S_NEWLINE;
          end else if (bus.ch_data == 8'h08) begin
            state_d = S_BKSP;
            if (cur_col != 7'd0) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = cell_addr(cur_row, cur_col - 7'd1);
              mem_wdata_d = BLANK;
            end else if (cur_row != top_row) begin
              mem_we_d    = 1'b1;
              mem_addr_d  = cell_addr(row_dec(cur_row), 7'(COLS - 1));
              mem_wdata_d = BLANK;
            end
          end
        end
      end
      S_WRITE: begin
        if (cur_col < 7'(COLS - 1)) begin
          cur_col_d = cur_col + 7'd1;
          state_d   = S_IDLE;
        end else begin
          state_d = S_NEWLINE;
        end
      end
      S_NEWLINE: begin
        cur_col_d = 7'd0;
        if (row_inc(cur_row) != top_row) begin
          cur_row_d = row_inc(cur_row);
          state_d   = S_IDLE;
        end else begin
          // bottom line reached: recycle the top physical row as the new bottom line
          cur_row_d   = top_row;
          state_d     = S_CLR_LINE;
          mem_we_d    = 1'b1;
          mem_addr_d  = cell_addr(top_row, 7'd0);
          mem_wdata_d = BLANK;
          cnt_d       = AW'(1);
        end
      end
      S_CLR_LINE: begin
        if (cnt == AW'(COLS)) begin
          top_row_d = row_inc(top_row);
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cell_addr(cur_row, cnt[6:0]);
          mem_wdata_d = BLANK;
          cnt_d       = cnt + AW'(1);
        end
      end
      S_BKSP: begin
        if (cur_col != 7'd0) begin
          cur_col_d = cur_col - 7'd1;
        end else if (cur_row != top_row) begin
          cur_row_d = row_dec(cur_row);
          cur_col_d = 7'(COLS - 1);
        end
        state_d = S_IDLE;
      end
      default: state_d = S_CLR_ALL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_CLR_ALL;
      cnt       <= '0;
      cur_row   <= '0;
      cur_col   <= '0;
      top_row   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= BLANK;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      cur_row   <= cur_row_d;
      cur_col   <= cur_col_d;
      top_row   <= top_row_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

  assign bus.ch_ready  = (state == S_IDLE);
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.top_row   = top_row;
  assign bus.cur_row   = cur_row;
  assign bus.cur_col   = cur_col;

`ifdef CURSOR_BLINK_EN
  logic [31:0] blink_cnt;
  logic        vis_q;

  // typing restarts the blink phase with the cursor shown
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      vis_q     <= 1'b1;
    end else if (accept) begin
      blink_cnt <= '0;
      vis_q     <= 1'b1;
    end else if (blink_cnt == 32'(BLINK_CYCLES - 1)) begin
      blink_cnt <= '0;
      vis_q     <= ~vis_q;
    end else begin
      blink_cnt <= blink_cnt + 32'd1;
    end
  end

  assign bus.cursor_vis = vis_q;
`else
  assign bus.cursor_vis = 1'b1;
`endif

endmodule

// File: tb/tb_vgamem_console_ctrl.sv
// Bench for vgamem_console_ctrl: directed table, corner sequences and random
// character streams checked against a screen-level reference model.
module tb_vgamem_console_ctrl;
  localparam int COLS  = 70;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  vgamem_console_if bus();
  vgamem_console_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int addr; int data; } wr_t;
  wr_t wq[$];
  wr_t eq[$];

  always @(negedge clk)
    if (!rst && bus.mem_we)
      wq.push_back('{cyc, int'(bus.mem_addr), int'(bus.mem_wdata)});

  int m_row, m_col, m_top;

  typedef struct {
    logic [7:0] ch;
    int row, col, top, nwr, addr0, data0;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic m_push(input int addr, input int data);
    eq.push_back('{0, addr, data});
  endtask

  task automatic m_newline();
    m_col = 0;
    if ((m_row + 1) % ROWS != m_top) m_row = (m_row + 1) % ROWS;
    else begin
      m_row = m_top;
      for (int k = 0; k < COLS; k++) m_push(m_row * COLS + k, 32);
      m_top = (m_top + 1) % ROWS;
    end
  endtask

  task automatic model_char(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      m_push(m_row * COLS + m_col, int'(c));
      if (m_col < COLS - 1) m_col++;
      else m_newline();
    end else if (c == 8'h0A || c == 8'h0D) begin
      m_newline();
    end else if (c == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        m_push(m_row * COLS + m_col, 32);
      end else if (m_row != m_top) begin
        m_row = (m_row + ROWS - 1) % ROWS;
        m_col = COLS - 1;
        m_push(m_row * COLS + m_col, 32);
      end
    end
  endtask

  task automatic wait_ready(output int rc);
    int n;
    n = 0;
    rc = -1;
    while (n < 5000) begin
      @(negedge clk);
      if (bus.ch_ready) begin
        rc = cyc;
        break;
      end
      n++;
    end
    if (rc < 0) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: ch_ready low for 5000 cycles, required high");
    end
  endtask

  task automatic send(input logic [7:0] c, output int acc);
    int n;
    n = 0;
    @(negedge clk);
    bus.ch_valid = 1'b1;
    bus.ch_data  = c;
    while (!bus.ch_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ch_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: char %0h never accepted, required acceptance", c);
      bus.ch_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    @(posedge clk);
    #1 bus.ch_valid = 1'b0;
    model_char(c);
  endtask

  task automatic settle(input string name);
    int rc, bad, first;
    wait_ready(rc);
    check({name, "_nwr"}, wq.size(), eq.size());
    bad = 0;
    first = -1;
    for (int i = 0; i < wq.size() && i < eq.size(); i++)
      if (wq[i].addr != eq[i].addr || wq[i].data != eq[i].data) begin
        bad++;
        if (first < 0) first = i;
      end
    check({name, "_wr_mismatches"}, bad, 0);
    if (first >= 0) check({name, "_first_bad_addr"}, wq[first].addr, eq[first].addr);
    check({name, "_cur_row"}, int'(bus.cur_row), m_row);
    check({name, "_cur_col"}, int'(bus.cur_col), m_col);
    check({name, "_top_row"}, int'(bus.top_row), m_top);
    wq.delete();
    eq.delete();
  endtask

  task automatic reset_init(input string name);
    int rc, bad;
    rst = 1'b1;
    bus.ch_valid = 1'b0;
    bus.ch_data  = 8'h00;
    repeat (3) @(negedge clk);
    check({name, "_rst_we"}, int'(bus.mem_we), 0);
    check({name, "_rst_addr"}, int'(bus.mem_addr), 0);
    check({name, "_rst_wdata"}, int'(bus.mem_wdata), 32);
    check({name, "_rst_ready"}, int'(bus.ch_ready), 0);
    check({name, "_rst_top"}, int'(bus.top_row), 0);
    check({name, "_rst_cursor"}, int'(bus.cur_row) * 100 + int'(bus.cur_col), 0);
    check({name, "_rst_vis"}, int'(bus.cursor_vis), 1);
    wq.delete();
    eq.delete();
    rst = 1'b0;
    wait_ready(rc);
    check({name, "_init_count"}, wq.size(), CELLS);
    bad = 0;
    foreach (wq[i])
      if (wq[i].addr != i || wq[i].data != 32 || wq[i].cyc != wq[0].cyc + i) bad++;
    check({name, "_init_seq_errors"}, bad, 0);
    if (wq.size() > 0) check({name, "_init_ready_delay"}, rc - wq[wq.size()-1].cyc, 1);
    check({name, "_init_top"}, int'(bus.top_row), 0);
    check({name, "_init_cursor"}, int'(bus.cur_row) * 100 + int'(bus.cur_col), 0);
    m_row = 0;
    m_col = 0;
    m_top = 0;
    wq.delete();
    eq.delete();
  endtask

  initial begin
    int acc, rc, n;
    logic [7:0] c;

    vecs[0]  = '{8'h07, 0,  1, 0, 0,  0, 0};
    vecs[1]  = '{8'h08, 0,  0, 0, 1,  0, 8'h20};
    vecs[2]  = '{8'h08, 0,  0, 0, 0,  0, 0};
    vecs[3]  = '{8'h0A, 1,  0, 0, 0,  0, 0};
    vecs[4]  = '{8'h08, 0, 69, 0, 1, 69, 8'h20};
    vecs[5]  = '{8'h0D, 1,  0, 0, 0,  0, 0};
    vecs[6]  = '{8'h7E, 1,  1, 0, 1, 70, 8'h7E};
    vecs[7]  = '{8'h1F, 1,  1, 0, 0,  0, 0};
    vecs[8]  = '{8'h20, 1,  2, 0, 1, 71, 8'h20};
    vecs[9]  = '{8'h7F, 1,  2, 0, 0,  0, 0};
    vecs[10] = '{8'h08, 1,  1, 0, 1, 71, 8'h20};

    bus.ch_valid = 1'b0;
    bus.ch_data  = 8'h00;
    reset_init("por");

    // single printable: write one cycle after accept, ready two cycles after
    send(8'h41, acc);
    wait_ready(rc);
    check("lat_nwr", wq.size(), 1);
    if (wq.size() > 0) begin
      check("lat_write_delay", wq[0].cyc - acc, 1);
      check("lat_addr", wq[0].addr, 0);
      check("lat_data", wq[0].data, 8'h41);
    end
    check("lat_ready_delay", rc - acc, 2);
    check("lat_cur_col", int'(bus.cur_col), 1);
    wq.delete();
    eq.delete();

    foreach (vecs[i]) begin
      send(vecs[i].ch, acc);
      wait_ready(rc);
      check($sformatf("vec%0d_nwr", i), wq.size(), vecs[i].nwr);
      if (vecs[i].nwr > 0 && wq.size() > 0) begin
        check($sformatf("vec%0d_addr", i), wq[0].addr, vecs[i].addr0);
        check($sformatf("vec%0d_data", i), wq[0].data, vecs[i].data0);
      end
      check($sformatf("vec%0d_row", i), int'(bus.cur_row), vecs[i].row);
      check($sformatf("vec%0d_col", i), int'(bus.cur_col), vecs[i].col);
      check($sformatf("vec%0d_top", i), int'(bus.top_row), vecs[i].top);
      wq.delete();
      eq.delete();
    end

    // seventy chars back-to-back from (0,0): wrap to (1,0) without a scroll
    reset_init("wrap");
    for (int i = 0; i < COLS; i++) send(8'h42, acc);
    wait_ready(rc);
    if (wq.size() > 0) check("wrap_last_addr", wq[wq.size()-1].addr, 69);
    check("wrap_cursor", int'(bus.cur_row) * 100 + int'(bus.cur_col), 100);
    settle("wrap");
    send(8'h0A, acc);
    for (int i = 0; i < 5; i++) send(8'h43, acc);
    settle("to_2_5");
    send(8'h0A, acc);
    settle("nl_plain");
    check("nl_plain_cursor", int'(bus.cur_row) * 100 + int'(bus.cur_col), 300);

    // scroll from the bottom line, then again from the recycled row
    for (int i = 0; i < 26; i++) send(8'h0A, acc);
    for (int i = 0; i < 10; i++) send(8'h44, acc);
    settle("to_29_10");
    send(8'h0D, acc);
    wait_ready(rc);
    if (wq.size() > 0) begin
      check("scroll1_first_addr", wq[0].addr, 0);
      check("scroll1_ready_low", int'(wq[wq.size()-1].cyc < rc), 1);
    end
    check("scroll1_top", int'(bus.top_row), 1);
    settle("scroll1");
    send(8'h0D, acc);
    wait_ready(rc);
    if (wq.size() > 0) check("scroll2_first_addr", wq[0].addr, 70);
    check("scroll2_top", int'(bus.top_row), 2);
    settle("scroll2");

    // random streams, sometimes two chars back-to-back so the second stalls on valid
    for (int it = 0; it < 300; it++) begin
      n = $urandom_range(1, 2);
      for (int k = 0; k < n; k++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 60)      c = 8'($urandom_range(32, 126));
        else if (r < 72) c = 8'h0A;
        else if (r < 78) c = 8'h0D;
        else if (r < 90) c = 8'h08;
        else             c = 8'($urandom_range(0, 255));
        send(c, acc);
      end
      settle($sformatf("rnd%0d", it));
    end

    // reset on the 30th cycle of a line clear
    n = 0;
    while ((m_row + 1) % ROWS != m_top && n < ROWS) begin
      send(8'h0A, acc);
      settle("pre_scroll");
      n++;
    end
    send(8'h0A, acc);
    n = 0;
    while (wq.size() < 30 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("midclr_reached_30", wq.size(), 30);
    rst = 1'b1;
    #1;
    check("midclr_we", int'(bus.mem_we), 0);
    check("midclr_addr", int'(bus.mem_addr), 0);
    check("midclr_wdata", int'(bus.mem_wdata), 32);
    check("midclr_ready", int'(bus.ch_ready), 0);
    check("midclr_top", int'(bus.top_row), 0);
    check("midclr_cursor", int'(bus.cur_row) * 100 + int'(bus.cur_col), 0);
    reset_init("midclr");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
